ram_access_ctrl: RTL
====================

Name: ram_access_ctrl

Overview:
- Bus initiator that drives the 512x32 synchronous-read RAM on behalf of the CPU datapath.
- Accepts single-word write requests and single- or burst-read requests (up to 16 words) from the control unit.
- Sequences the RAM's read, write, address and data-in pins, and waits out the registered-address read latency.
- Returns read data with valid/last strobes; sits between the control unit/MDR and the RAM.

Parameters:
- ADDR_W, 9, RAM word-address width; address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 32, data word width.
- READ_LATENCY, 1, number of WAIT cycles between the address-issue cycle and the capture edge. Must be ≥1; 1 matches the RAM.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, request accepted on edge where req_valid&&req_ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  start word address
- req_len  in  4  read beats minus 1 (0..15); ignored for writes
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle strobe: read word on rsp_rdata, or write completion
- rsp_last  out  1  qualifies rsp_valid: final response of the request
- rsp_rdata  out  DATA_W  captured read word, held until next capture
- ram_read  out  1  to RAM read
- ram_write  out  1  to RAM write
- ram_address  out  ADDR_W  to RAM address (registered)
- ram_data_in  out  DATA_W  to RAM write data (registered)
- ram_data_out  in  DATA_W  from RAM; valid in the cycle after the RAM clocks an address

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all outputs 0 (req_ready=0 while reset_n=0); beat counter and address cleared.
  - Reset during WRITE drops ram_write immediately; the write is aborted if reset precedes the edge.
  - Reset during a burst abandons it; no further rsp_valid.
- States: IDLE, WRITE, ISSUE, WAIT, DONE.
- req_ready = (state==IDLE) && reset_n. Request fields are sampled only on the accept edge; later changes are ignored.
- IDLE:
  - On accept of a write: latch addr/wdata into ram_address/ram_data_in → WRITE.
  - On accept of a read: latch addr, beats=req_len → ISSUE.
- WRITE (1 cycle): ram_write=1, ram_read=0. The RAM writes at the closing edge → DONE.
- ISSUE (1 cycle): ram_read=1, ram_address = current beat address. The RAM latches the address at the closing edge → WAIT. Wait counter loads READ_LATENCY.
- WAIT (READ_LATENCY cycles): ram_read=1, ram_address held.
  - At the closing edge of the last WAIT cycle, rsp_rdata <= ram_data_out.
  - If beats remain: ram_address <= ram_address+1 (511+1 wraps to 0), beat count decrements → ISSUE, with rsp_valid=1, rsp_last=0 during that ISSUE cycle.
  - If no beats remain → DONE.
- DONE (1 cycle): rsp_valid=1, rsp_last=1, req_ready=0 → IDLE.
  - For writes, rsp_rdata is unchanged.
- ram_read and ram_write are never both 1. Both are 0 in IDLE and DONE.
- Timing, READ_LATENCY=1:
  - Single read accepted at edge E0: ISSUE E0–E1, WAIT E1–E2, capture at E2, rsp_valid E2–E3, req_ready=1 after E3.
  - A burst of N words gives response strobes 2 cycles apart. The final strobe is in DONE.
  - Write accepted at E0: RAM write at E1, rsp_valid/rsp_last E1–E2, ready after E2.
- rsp_valid and rsp_last are registered, never combinational from inputs. rsp_last=0 whenever rsp_valid=0.
- No back-pressure on responses; the consumer must take each strobe.

Test Plan:
- RAM preloaded: [0]=09000069, [1]=09100002, [2]=00800047. Read addr 0, len 0 → one rsp_valid+rsp_last with rsp_rdata=09000069, exactly 2 edges after accept; req_ready low for 3 cycles.
- Burst read addr 0, len 2 → rsp_rdata 09000069, 09100002, 00800047 on strobes 2 cycles apart; rsp_last only on the third; ram_address sequence 0,1,2.
- Write addr 0x8E data 000000A5 → ram_write high exactly one cycle with ram_address=08E; completion strobe with rsp_last=1. Subsequent read of 0x8E → rsp_rdata=000000A5.
- Wrap: burst read addr 510 (0x1FE), len 3 → ram_address 1FE, 1FF, 000, 001; four strobes; rsp_last on the fourth.
- Reset mid-op: drop reset_n during WRITE before the edge (addr 0x10, data DEADBEEF) → ram_write falls immediately; memory[0x10] unchanged; all outputs 0. After release, req_ready=1 and a new read succeeds.
- Busy handling: hold req_valid=1 with changing req_addr during a 4-beat burst → no new accept until IDLE; burst addresses unaffected; ram_read/ram_write never simultaneously high (assertion).

Source files
------------

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - RAM bus initiator: single-word writes, 1..16 word burst reads
module ram_access_ctrl #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_last,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  logic [2:0]       state;
  logic [3:0]       beats;
  logic [CNT_W-1:0] wait_cnt;

  // Strobes decode straight from the state register so reset removes them at once.
  assign req_ready = (state == S_IDLE) && reset_n;
  assign ram_write = (state == S_WRITE);
  assign ram_read  = (state == S_ISSUE) || (state == S_WAIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      beats       <= '0;
      wait_cnt    <= '0;
      ram_address <= '0;
      ram_data_in <= '0;
      rsp_rdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_last    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            ram_address <= req_addr;
            if (req_write) begin
              ram_data_in <= req_wdata;
              state       <= S_WRITE;
            end else begin
              beats <= req_len;
              state <= S_ISSUE;
            end
          end
        end
        S_WRITE: begin
          rsp_valid <= 1'b1;
          rsp_last  <= 1'b1;
          state     <= S_DONE;
        end
        S_ISSUE: begin
          wait_cnt <= CNT_W'(READ_LATENCY);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == CNT_W'(1)) begin
            rsp_rdata <= ram_data_out;
            rsp_valid <= 1'b1;
            if (beats != 4'd0) begin
              // Address arithmetic wraps naturally at the top of the RAM.
              ram_address <= ram_address + ADDR_W'(1);
              beats       <= beats - 4'd1;
              state       <= S_ISSUE;
            end else begin
              rsp_last <= 1'b1;
              state    <= S_DONE;
            end
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
